lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Memory-stage sequencer placed between the EX/MEM pipeline register and the data-memory bus port. It accepts one instruction at a time from the EX/MEM register using the valid/ready handshake, and drives Mready back to it. For loads and stores it runs a single request/response bus transaction, including byte-lane alignment and load sign/zero extension. Non-memory instructions pass straight through. Results go to the MEM/WB register through a second valid/ready handshake.

Parameters:
DATA_WIDTH, 32, data and address width.
WMASK_LENGTH, 4, width of the byte-mask field from the pipeline register.
ROPCODE_LENGTH, 3, width of the load-extension opcode.

Ports:
clk  in  1  clock.
resetn  in  1  synchronous reset, active-low.
m_valid_in  in  1  EX/MEM register holds a valid instruction.
m_ready_out  out  1  stage can accept; wired to Mready.
mem_read  in  1  instruction is a load.
mem_write  in  1  instruction is a store.
wmask  in  WMASK_LENGTH  byte mask at word offset 0 (0001/0011/1111).
ropcode  in  ROPCODE_LENGTH  load extension type.
addr  in  DATA_WIDTH  effective address (ALUResultM).
wdata  in  DATA_WIDTH  store data, unshifted.
req_valid  out  1  bus request valid.
req_ready  in  1  bus accepts request.
req_we  out  1  request is a write.
req_addr  out  DATA_WIDTH  word-aligned address (addr with [1:0] cleared).
req_wdata  out  DATA_WIDTH  lane-shifted store data.
req_wstrb  out  WMASK_LENGTH  lane-shifted byte strobe.
resp_valid  in  1  bus response valid.
resp_ready  out  1  controller accepts response.
resp_rdata  in  DATA_WIDTH  read word.
resp_err  in  1  bus error.
w_valid  out  1  result valid to MEM/WB.
w_ready  in  1  MEM/WB accepts.
load_data  out  DATA_WIDTH  extended load result (0 for non-loads).
access_fault  out  1  misalignment, illegal combination, or bus error on this instruction.

Behaviour:
- States: IDLE, REQ, RESP, OUT.
- Reset value of every output is 0, state is IDLE, and all latched fields are cleared. Reset mid-transaction abandons the transaction immediately: req_valid and resp_ready drop on the next edge.
- m_ready_out = 1 only in IDLE. Acceptance happens on an edge where m_valid_in && m_ready_out. On acceptance, addr, wdata, wmask, ropcode, mem_read and mem_write are latched.
- On acceptance, the next state is chosen as follows:
  - Neither mem_read nor mem_write set: go to OUT with load_data=0 and access_fault=0. Latency is 1 cycle.
  - Both mem_read and mem_write set: go to OUT with access_fault=1 and no bus transaction.
  - The access is misaligned (halfword with addr[0]=1, or word with addr[1:0]≠0): go to OUT with access_fault=1 and no bus transaction.
  - Otherwise: go to REQ.
- REQ:
  - req_valid=1 and req_we=mem_write.
  - req_wstrb = wmask << addr[1:0].
  - req_wdata = wdata << (8*addr[1:0]).
  - The request is held stable until req_ready. The edge on which req_valid && req_ready is seen moves the state to RESP.
- RESP:
  - resp_ready=1.
  - On resp_valid, latch access_fault=resp_err and go to OUT.
  - For loads without error: shift resp_rdata right by 8*addr[1:0], then extend per ropcode (LB sign-8, LH sign-16, LW, LBU zero-8, LHU zero-16). An undefined ropcode yields the full shifted word.
  - For stores, or when resp_err=1: load_data=0.
- OUT:
  - w_valid=1, with load_data and access_fault held stable.
  - When w_valid && w_ready, go to IDLE.
- Outside RESP, resp_ready=0, so a stray response is never consumed.
- At most one instruction is in flight. Minimum memory-instruction latency is 3 cycles (accept→REQ→RESP→OUT) with req_ready and resp_valid both asserted immediately.
- Back-to-back throughput for non-memory instructions is one per 2 cycles. Pipelined bypass is out of scope for this block.

Decomposition:
- Shared package holds the ropcode encodings: LB=0, LH=1, LW=2, LBU=4, LHU=5.
- The package also holds the state encoding and the WMASK constants (BYTE=4'b0001, HALF=4'b0011, WORD=4'b1111).
- One combinational sub-module, lsu_load_ext (shift plus sign/zero extension), so it can be reused by a later cache path.

Test Plan:
- Non-memory instruction, w_ready=1 → m_ready_out low one cycle; w_valid the cycle after acceptance with load_data=0 and access_fault=0; no req_valid.
- Store with addr=0x8000_0006, wmask=0011, wdata=0x0000_ABCD, and req_ready delayed 3 cycles → req_addr=0x8000_0004, req_wstrb=1100, req_wdata=0xABCD_0000, all held stable during the stall; w_valid after the response.
- LB at addr offset 3 with resp_rdata=0x80FF_FFFF → load_data=0xFFFF_FF80. Repeat with LBU → load_data=0x0000_0080.
- LW at addr=0x...2 → access_fault=1 in OUT, no req_valid ever raised.
- Load with resp_err=1 → access_fault=1, load_data=0. Then hold w_ready=0 for 4 cycles → w_valid and outputs stable, m_ready_out stays 0 until the handshake completes.
- resetn asserted while in RESP with resp_valid low → next cycle state IDLE, all outputs 0. A resp_valid pulse after reset is not accepted (resp_ready=0).

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the memory-stage sequencer.
//   - state_t      : sequencer states
//   - ROP_*        : load-extension opcodes
//   - WMASK_*      : byte masks at word offset 0 as delivered by EX/MEM
//   - misaligned() : alignment rule for halfword/word accesses
package lsu_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam logic [2:0] ROP_LB  = 3'd0;
  localparam logic [2:0] ROP_LH  = 3'd1;
  localparam logic [2:0] ROP_LW  = 3'd2;
  localparam logic [2:0] ROP_LBU = 3'd4;
  localparam logic [2:0] ROP_LHU = 3'd5;

  localparam logic [3:0] WMASK_BYTE = 4'b0001;
  localparam logic [3:0] WMASK_HALF = 4'b0011;
  localparam logic [3:0] WMASK_WORD = 4'b1111;

  // Halfwords must sit on an even byte, words on a word boundary.
  function automatic logic misaligned(input logic is_half, input logic is_word,
                                      input logic [1:0] offset);
    return (is_half && offset[0]) || (is_word && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load-data aligner: moves the addressed byte lane down to bit 0 and then
// sign/zero extends according to the load opcode. Purely combinational so a
// future cache path can reuse it unchanged.
// Ports:
//   rdata   in  DATA_WIDTH      raw word from memory
//   offset  in  2               byte offset of the access within the word
//   ropcode in  ROPCODE_LENGTH  extension type (LB/LH/LW/LBU/LHU)
//   data    out DATA_WIDTH      aligned, extended result
module lsu_load_ext #(
  parameter int DATA_WIDTH     = 32,
  parameter int ROPCODE_LENGTH = 3
) (
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                offset,
  input  logic [ROPCODE_LENGTH-1:0] ropcode,
  output logic [DATA_WIDTH-1:0]     data
);
  import lsu_mem_ctrl_pkg::*;

  logic [DATA_WIDTH-1:0] shifted;

  // NOTE: every variable written in always_comb gets a value at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (ropcode)
      ROPCODE_LENGTH'(ROP_LB):  data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      ROPCODE_LENGTH'(ROP_LH):  data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      ROPCODE_LENGTH'(ROP_LW):  data = shifted;
      ROPCODE_LENGTH'(ROP_LBU): data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      ROPCODE_LENGTH'(ROP_LHU): data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default:                  data = shifted; // undefined opcode: whole shifted word
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage sequencer between the EX/MEM register and the data-memory bus.
// Takes one instruction at a time, runs at most one request/response bus
// transaction for it, and hands the result to MEM/WB.
// Ports:
//   clk, resetn (sync, active-low)
//   m_valid_in / m_ready_out           handshake with EX/MEM (m_ready_out = Mready)
//   mem_read, mem_write, wmask,
//   ropcode, addr, wdata               instruction fields, latched on acceptance
//   req_valid/ready, req_we, req_addr,
//   req_wdata, req_wstrb               bus request channel
//   resp_valid/ready, resp_rdata,
//   resp_err                           bus response channel
//   w_valid / w_ready, load_data,
//   access_fault                       result handshake with MEM/WB
module lsu_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int WMASK_LENGTH   = 4,
  parameter int ROPCODE_LENGTH = 3
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      m_valid_in,
  output logic                      m_ready_out,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [WMASK_LENGTH-1:0]   wmask,
  input  logic [ROPCODE_LENGTH-1:0] ropcode,
  input  logic [DATA_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic                      req_we,
  output logic [DATA_WIDTH-1:0]     req_addr,
  output logic [DATA_WIDTH-1:0]     req_wdata,
  output logic [WMASK_LENGTH-1:0]   req_wstrb,
  input  logic                      resp_valid,
  output logic                      resp_ready,
  input  logic [DATA_WIDTH-1:0]     resp_rdata,
  input  logic                      resp_err,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic [DATA_WIDTH-1:0]     load_data,
  output logic                      access_fault
);
  import lsu_mem_ctrl_pkg::*;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]     addr_q, wdata_q, load_data_q;
  logic [WMASK_LENGTH-1:0]   wmask_q;
  logic [ROPCODE_LENGTH-1:0] ropcode_q;
  logic                      read_q, write_q, fault_q;

  logic                  accept;
  logic                  is_half, is_word, bad_access;
  logic [DATA_WIDTH-1:0] ext_data;

  assign accept = m_valid_in && m_ready_out;

  // Access size comes from the extension opcode for loads and from the byte
  // mask for stores; it only matters for the alignment check.
  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    if (mem_read) begin
      is_half = (ropcode == ROPCODE_LENGTH'(ROP_LH)) || (ropcode == ROPCODE_LENGTH'(ROP_LHU));
      is_word = (ropcode == ROPCODE_LENGTH'(ROP_LW));
    end else if (mem_write) begin
      is_half = (wmask == WMASK_LENGTH'(WMASK_HALF));
      is_word = (wmask == WMASK_LENGTH'(WMASK_WORD));
    end
  end

  assign bad_access = (mem_read && mem_write) || misaligned(is_half, is_word, addr[1:0]);

  lsu_load_ext #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ROPCODE_LENGTH(ROPCODE_LENGTH)
  ) u_load_ext (
    .rdata  (resp_rdata),
    .offset (addr_q[1:0]),
    .ropcode(ropcode_q),
    .data   (ext_data)
  );

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) begin
        if ((!mem_read && !mem_write) || bad_access) state_next = ST_OUT;
        else                                         state_next = ST_REQ;
      end
      ST_REQ:  if (req_ready)  state_next = ST_RESP;
      ST_RESP: if (resp_valid) state_next = ST_OUT;
      ST_OUT:  if (w_ready)    state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Latched instruction fields and result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ropcode_q   <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q      <= addr;
        wdata_q     <= wdata;
        wmask_q     <= wmask;
        ropcode_q   <= ropcode;
        read_q      <= mem_read;
        write_q     <= mem_write;
        load_data_q <= '0;
        fault_q     <= bad_access;
      end
      if (state == ST_RESP && resp_valid) begin
        fault_q     <= resp_err;
        load_data_q <= (read_q && !resp_err) ? ext_data : '0;
      end
    end
  end

  // Outputs. m_ready_out is also masked by resetn so nothing is accepted
  // while the stage is held in reset.
  always_comb begin
    m_ready_out = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    resp_ready  = 1'b0;
    w_valid     = 1'b0;
    case (state)
      ST_IDLE: m_ready_out = resetn;
      ST_REQ: begin
        req_valid = 1'b1;
        req_we    = write_q;
        req_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
        req_wstrb = wmask_q << addr_q[1:0];
        req_wdata = wdata_q << {addr_q[1:0], 3'b000};
      end
      ST_RESP: resp_ready = 1'b1;
      ST_OUT:  w_valid    = 1'b1;
      default: ;
    endcase
  end

  assign load_data    = load_data_q;
  assign access_fault = fault_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: reset, pass-through, stalled store,
// load extension variants, faults, output backpressure and mid-transaction reset.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_valid_in;
  logic        m_ready_out;
  logic        mem_read, mem_write;
  logic [3:0]  wmask;
  logic [2:0]  ropcode;
  logic [31:0] addr, wdata;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        w_valid, w_ready;
  logic [31:0] load_data;
  logic        access_fault;

  int n_checks = 0;
  int n_errors = 0;

  lsu_mem_ctrl dut (
    .clk(clk), .resetn(resetn),
    .m_valid_in(m_valid_in), .m_ready_out(m_ready_out),
    .mem_read(mem_read), .mem_write(mem_write), .wmask(wmask), .ropcode(ropcode),
    .addr(addr), .wdata(wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .w_valid(w_valid), .w_ready(w_ready), .load_data(load_data),
    .access_fault(access_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Presents a load with req_ready and resp_valid already high, so the
  // result must appear on the third edge after acceptance. Returns at the
  // first sample point in OUT; caller owns w_ready.
  task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] rop,
                          input logic [31:0] rdata, input logic err,
                          input logic [31:0] exp_data, input logic exp_fault);
    m_valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    addr = a; ropcode = rop; wmask = 4'b0001; wdata = 32'h0;
    req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = rdata; resp_err = err;
    @(negedge clk);
    m_valid_in = 1'b0;
    check1({tag, " req_valid"}, req_valid, 1'b1);
    check1({tag, " req_we"}, req_we, 1'b0);
    check({tag, " req_addr"}, req_addr, a & 32'hFFFF_FFFC);
    check1({tag, " resp_ready in REQ"}, resp_ready, 1'b0);
    @(negedge clk);
    check1({tag, " resp_ready"}, resp_ready, 1'b1);
    check1({tag, " req_valid in RESP"}, req_valid, 1'b0);
    @(negedge clk);
    req_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0;
    check1({tag, " w_valid"}, w_valid, 1'b1);
    check({tag, " load_data"}, load_data, exp_data);
    check1({tag, " access_fault"}, access_fault, exp_fault);
  endtask

  initial begin
    resetn = 1'b0; m_valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    wmask = 4'h0; ropcode = 3'd0; addr = 32'h0; wdata = 32'h0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'h0; resp_err = 1'b0;
    w_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check1("rst m_ready_out", m_ready_out, 1'b0);
    check1("rst req_valid", req_valid, 1'b0);
    check1("rst resp_ready", resp_ready, 1'b0);
    check1("rst w_valid", w_valid, 1'b0);
    check("rst load_data", load_data, 32'h0);
    check1("rst access_fault", access_fault, 1'b0);
    check("rst req_addr", req_addr, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    check1("idle m_ready_out", m_ready_out, 1'b1);

    // Non-memory instruction passes straight through in one cycle
    w_ready = 1'b1;
    m_valid_in = 1'b1; addr = 32'h0000_1234; wdata = 32'h5555_AAAA;
    @(negedge clk);
    m_valid_in = 1'b0;
    check1("alu m_ready_out", m_ready_out, 1'b0);
    check1("alu w_valid", w_valid, 1'b1);
    check("alu load_data", load_data, 32'h0);
    check1("alu access_fault", access_fault, 1'b0);
    check1("alu req_valid", req_valid, 1'b0);
    @(negedge clk);
    check1("alu done w_valid", w_valid, 1'b0);
    check1("alu done m_ready_out", m_ready_out, 1'b1);
    check1("alu done req_valid", req_valid, 1'b0);

    // Store, halfword at offset 2, with req_ready held off for 3 cycles
    m_valid_in = 1'b1; mem_write = 1'b1; mem_read = 1'b0;
    addr = 32'h8000_0006; wmask = 4'b0011; wdata = 32'h0000_ABCD;
    @(negedge clk);
    m_valid_in = 1'b0; addr = 32'h0; wdata = 32'h0; wmask = 4'h0; mem_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check1("st stall req_valid", req_valid, 1'b1);
      check1("st stall req_we", req_we, 1'b1);
      check("st stall req_addr", req_addr, 32'h8000_0004);
      check("st stall req_wstrb", {28'h0, req_wstrb}, 32'h0000_000C);
      check("st stall req_wdata", req_wdata, 32'hABCD_0000);
      check1("st stall m_ready_out", m_ready_out, 1'b0);
      if (i < 2) @(negedge clk);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check1("st req dropped", req_valid, 1'b0);
    check1("st resp_ready", resp_ready, 1'b1);
    resp_valid = 1'b1; resp_rdata = 32'hDEAD_BEEF; resp_err = 1'b0;
    @(negedge clk);
    resp_valid = 1'b0;
    check1("st w_valid", w_valid, 1'b1);
    check("st load_data", load_data, 32'h0);
    check1("st access_fault", access_fault, 1'b0);
    @(negedge clk);
    check1("st done w_valid", w_valid, 1'b0);

    // Load extension variants, minimum 3-cycle latency
    run_load("lb", 32'h1000_0003, 3'd0, 32'h80FF_FFFF, 1'b0, 32'hFFFF_FF80, 1'b0);
    @(negedge clk);
    run_load("lbu", 32'h1000_0003, 3'd4, 32'h80FF_FFFF, 1'b0, 32'h0000_0080, 1'b0);
    @(negedge clk);
    run_load("lh", 32'h2000_0002, 3'd1, 32'h8001_1234, 1'b0, 32'hFFFF_8001, 1'b0);
    @(negedge clk);
    run_load("lhu", 32'h2000_0002, 3'd5, 32'h8001_1234, 1'b0, 32'h0000_8001, 1'b0);
    @(negedge clk);
    run_load("lw", 32'h3000_0000, 3'd2, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);

    // Misaligned word load: fault, no bus request
    m_valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; ropcode = 3'd2;
    addr = 32'h3000_0002;
    @(negedge clk);
    m_valid_in = 1'b0; mem_read = 1'b0;
    check1("lw mis w_valid", w_valid, 1'b1);
    check1("lw mis access_fault", access_fault, 1'b1);
    check("lw mis load_data", load_data, 32'h0);
    check1("lw mis req_valid", req_valid, 1'b0);
    @(negedge clk);
    check1("lw mis after req_valid", req_valid, 1'b0);
    check1("lw mis after w_valid", w_valid, 1'b0);

    // Read and write both set: illegal, no bus request
    m_valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b1; ropcode = 3'd2;
    wmask = 4'b1111; addr = 32'h0000_0100;
    @(negedge clk);
    m_valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    check1("rw w_valid", w_valid, 1'b1);
    check1("rw access_fault", access_fault, 1'b1);
    check1("rw req_valid", req_valid, 1'b0);
    @(negedge clk);

    // Bus error on a load, then MEM/WB backpressure for 4 cycles
    w_ready = 1'b0;
    run_load("err", 32'h4000_0000, 3'd2, 32'h1234_5678, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("hold w_valid", w_valid, 1'b1);
      check1("hold access_fault", access_fault, 1'b1);
      check("hold load_data", load_data, 32'h0);
      check1("hold m_ready_out", m_ready_out, 1'b0);
    end
    w_ready = 1'b1;
    @(negedge clk);
    check1("hold done w_valid", w_valid, 1'b0);
    check1("hold done m_ready_out", m_ready_out, 1'b1);

    // Reset while waiting in RESP, then a stray response
    m_valid_in = 1'b1; mem_read = 1'b1; ropcode = 3'd2; addr = 32'h5000_0000;
    req_ready = 1'b1;
    @(negedge clk);
    m_valid_in = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    req_ready = 1'b0;
    check1("rr in RESP", resp_ready, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check1("rr resp_ready", resp_ready, 1'b0);
    check1("rr req_valid", req_valid, 1'b0);
    check1("rr w_valid", w_valid, 1'b0);
    check1("rr m_ready_out", m_ready_out, 1'b0);
    check1("rr access_fault", access_fault, 1'b0);
    check("rr load_data", load_data, 32'h0);
    resetn = 1'b1;
    resp_valid = 1'b1; resp_rdata = 32'hFFFF_FFFF; resp_err = 1'b1;
    @(negedge clk);
    check1("stray resp_ready", resp_ready, 1'b0);
    check1("stray m_ready_out", m_ready_out, 1'b1);
    resp_valid = 1'b0; resp_err = 1'b0;
    @(negedge clk);
    check1("stray w_valid", w_valid, 1'b0);
    check1("stray access_fault", access_fault, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
